cmp_sweep_seq: RTL

- Sequencer for the 2-bit operand comparator with red/green/blue indicator outputs.
- On a start request it drives every (a, b) operand pair into the comparator, in order, with a outer and b inner.
- Waits a programmable settle time per pair, samples the three colour flags, and accumulates per-colour hit counts.
- Used for board self-test and bring-up of the comparator path; sits between the control logic (start/abort) and the combinational comparator.

---
 rtl/cmp_sweep_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cmp_sweep_seq.sv
// cmp_sweep_seq: sweeps every (a, b) operand pair through an external 2-bit
// comparator. Operand a is the outer loop and b is the inner loop. Each pair is
// held for SETTLE cycles, then the red/green/blue flags are sampled once, and
// one hit counter per colour accumulates the results.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, abort                     sweep request / terminate sweep in progress
//   cmp_a, cmp_b                     operands driven to the comparator
//   cmp_red, cmp_green, cmp_blue     comparator flags
//   busy, done                       sweep in progress / one-cycle completion pulse
//   red_cnt, green_cnt, blue_cnt     per-colour hit counts
//   err_cnt                          (CMP_SEQ_ONEHOT_CHK_EN only) count of samples
//                                    whose flags are not exactly one-hot
//
// Optional feature macro: CMP_SEQ_ONEHOT_CHK_EN
module cmp_sweep_seq #(
   parameter int unsigned W      = 2,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNT_W  = 2*W+1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [W-1:0]     cmp_a,
   output logic [W-1:0]     cmp_b,
   input  logic             cmp_red,
   input  logic             cmp_green,
   input  logic             cmp_blue,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] red_cnt,
   output logic [CNT_W-1:0] green_cnt,
`ifdef CMP_SEQ_ONEHOT_CHK_EN
   output logic [CNT_W-1:0] blue_cnt,
   output logic [CNT_W-1:0] err_cnt
`else
   output logic [CNT_W-1:0] blue_cnt
`endif
);

   localparam int unsigned SET_W  = 4;
   localparam int unsigned PAIR_W = 2*W;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t              state_q, state_d;
   logic [PAIR_W-1:0]   pair_q, pair_d;
   logic [SET_W-1:0]    settle_q, settle_d;
   logic [CNT_W-1:0]    red_q, red_d;
   logic [CNT_W-1:0]    green_q, green_d;
   logic [CNT_W-1:0]    blue_q, blue_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
`ifdef CMP_SEQ_ONEHOT_CHK_EN
   logic [CNT_W-1:0]    err_q, err_d;
   logic                onehot_c;

   // Exactly one flag set: odd parity but not all three set.
   assign onehot_c = (cmp_red ^ cmp_green ^ cmp_blue) & ~(cmp_red & cmp_green & cmp_blue);
`endif

   // Next-state, operand sequencing and counter update.
   always_comb begin
      state_d  = state_q;
      pair_d   = pair_q;
      settle_d = settle_q;
      red_d    = red_q;
      green_d  = green_q;
      blue_d   = blue_q;
`ifdef CMP_SEQ_ONEHOT_CHK_EN
      err_d    = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               red_d    = '0;
               green_d  = '0;
               blue_d   = '0;
`ifdef CMP_SEQ_ONEHOT_CHK_EN
               err_d    = '0;
`endif
               pair_d   = '0;
               settle_d = '0;
               state_d  = DRIVE;
            end
         end
         DRIVE: begin
            settle_d = settle_q + SET_W'(1);
            if (abort) begin
               state_d = IDLE;
            end else if (settle_q == SET_W'(SETTLE - 1)) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            // The sample is taken even when the sweep is aborted this cycle.
            red_d   = red_q   + CNT_W'(cmp_red);
            green_d = green_q + CNT_W'(cmp_green);
            blue_d  = blue_q  + CNT_W'(cmp_blue);
`ifdef CMP_SEQ_ONEHOT_CHK_EN
            err_d   = err_q   + CNT_W'(~onehot_c);
`endif
            if (abort) begin
               state_d = IDLE;
            end else if (&pair_q) begin
               state_d = DONE;
            end else begin
               // {a,b} as one number: b wrapping carries into a.
               pair_d   = pair_q + PAIR_W'(1);
               settle_d = '0;
               state_d  = DRIVE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pair_q   <= '0;
         settle_q <= '0;
         red_q    <= '0;
         green_q  <= '0;
         blue_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef CMP_SEQ_ONEHOT_CHK_EN
         err_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         pair_q   <= pair_d;
         settle_q <= settle_d;
         red_q    <= red_d;
         green_q  <= green_d;
         blue_q   <= blue_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef CMP_SEQ_ONEHOT_CHK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign cmp_a     = pair_q[PAIR_W-1:W];
   assign cmp_b     = pair_q[W-1:0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign red_cnt   = red_q;
   assign green_cnt = green_q;
   assign blue_cnt  = blue_q;
`ifdef CMP_SEQ_ONEHOT_CHK_EN
   assign err_cnt   = err_q;
`endif

endmodule
